// File: rtl/shift_pkg.sv
// Shared types and constants for the multicycle shift unit.
package shift_pkg;

  typedef enum logic [1:0] {
    SHOP_SLL = 2'b00,
    SHOP_SRL = 2'b01,
    SHOP_SRA = 2'b11
  } shop_e;

  localparam int SHIFT_STEP = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

endpackage

// File: rtl/shift_unit_ctl_if.sv
// Request/response bundle between the microcode sequencer and the shift unit.
interface shift_unit_ctl_if #(
  parameter int WIDTH = 32
);
  import shift_pkg::*;

  localparam int WSHAM = $clog2(WIDTH);

  logic             req_valid;
  logic             req_ready;
  shop_e            req_op;
  logic [WIDTH-1:0] req_val;
  logic [WSHAM-1:0] req_sham;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_val;
  logic             busy;

  modport master (
    output req_valid, req_op, req_val, req_sham, flush, resp_ready,
    input  req_ready, resp_valid, resp_val, busy
  );

  modport slave (
    input  req_valid, req_op, req_val, req_sham, flush, resp_ready,
    output req_ready, resp_valid, resp_val, busy
  );
endinterface

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves val by 0..3 positions according to op.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic [1:0]       amt,
  input  shop_e            op,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = val << amt;
    case (op)
      SHOP_SRL: res = val >> amt;
      SHOP_SRA: res = WIDTH'($signed(val) >>> amt);
      // the reserved encoding falls through to a left shift
      default:  res = val << amt;
    endcase
  end

endmodule

// File: rtl/shift_unit_ctl.sv
// Iterative shift execution unit: accepts one request, shifts up to three
// positions per cycle, then holds the result until the consumer takes it.
module shift_unit_ctl
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  shift_unit_ctl_if.slave bus
);

  localparam int WSHAM = $clog2(WIDTH);

  state_e           state_q;
  state_e           state_next;
  logic [WIDTH-1:0] val_q;
  logic [WSHAM-1:0] rem_q;
  shop_e            op_q;

  logic             accept;
  logic             load;
  logic             advance;
  logic [1:0]       step;
  logic [WSHAM-1:0] rem_after;
  logic [WIDTH-1:0] step_val;

  assign bus.req_ready  = (state_q == S_IDLE) && !bus.flush;
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_val   = val_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign accept         = bus.req_valid && bus.req_ready;

  assign step      = (rem_q > WSHAM'(SHIFT_STEP)) ? 2'(SHIFT_STEP) : rem_q[1:0];
  assign rem_after = rem_q - WSHAM'(step);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .val (val_q),
    .amt (step),
    .op  (op_q),
    .res (step_val)
  );

  always_comb begin
    state_next = state_q;
    load       = 1'b0;
    advance    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          load       = 1'b1;
          state_next = (bus.req_sham != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        advance = 1'b1;
        if (rem_after == '0) state_next = S_DONE;
      end
      S_DONE: begin
        if (bus.resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // abort wins over both the incoming request and the response handshake
    if (bus.flush) begin
      state_next = S_IDLE;
      load       = 1'b0;
      advance    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      rem_q   <= '0;
      op_q    <= SHOP_SLL;
    end else begin
      state_q <= state_next;
      if (load) begin
        val_q <= bus.req_val;
        rem_q <= bus.req_sham;
        op_q  <= bus.req_op;
      end else if (advance) begin
        val_q <= step_val;
        rem_q <= rem_after;
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_ctl.sv
// Directed self-checking bench for shift_unit_ctl with hand-computed results.
module tb_shift_unit_ctl;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  shift_unit_ctl_if #(.WIDTH(32)) bus ();

  shift_unit_ctl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for resp_valid; lat counts cycles since the accepting edge.
  task automatic wait_resp(inout int lat, output logic busy_all);
    busy_all = 1'b1;
    while (!bus.resp_valid && lat < 60) begin
      busy_all = busy_all & bus.busy;
      tick();
      lat++;
    end
  endtask

  // Offers a request (req_ready must be high), returns latency to resp_valid.
  task automatic do_req(input logic [1:0] op, input logic [31:0] val, input logic [4:0] sham,
                        output int lat, output logic busy_all);
    bus.req_op    = shop_e'(op);
    bus.req_val   = val;
    bus.req_sham  = sham;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    wait_resp(lat, busy_all);
    $display("txn op=%0d val=%h sham=%0d -> resp_val=%h lat=%0d", op, val, sham, bus.resp_val, lat);
  endtask

  task automatic run_case(input string tag, input logic [1:0] op, input logic [31:0] val,
                          input logic [4:0] sham, input logic [31:0] exp_val, input int exp_lat);
    int   lat;
    logic busy_all;
    do_req(op, val, sham, lat, busy_all);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_val"}, bus.resp_val, exp_val);
    chk({tag, "_busy"}, 32'(busy_all), 32'd1);
    tick();
    chk({tag, "_idle"}, {30'd0, bus.req_ready, bus.resp_valid}, 32'b10);
  endtask

  initial begin
    int   lat;
    logic busy_all;
    logic [31:0] held;

    bus.req_valid  = 1'b0;
    bus.req_op     = SHOP_SLL;
    bus.req_val    = '0;
    bus.req_sham   = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b1;

    #3;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_resp_val", bus.resp_val, 32'd0);
    #20 rst_n = 1'b1;
    tick();

    run_case("sll5", 2'b00, 32'h0000_0001, 5'd5, 32'h0000_0020, 3);
    run_case("sra31", 2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 12);
    run_case("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 12);
    run_case("sra0", 2'b11, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1);
    run_case("sll3", 2'b00, 32'h0000_0001, 5'd3, 32'h0000_0008, 2);
    run_case("rsvd", 2'b10, 32'h0000_0003, 5'd2, 32'h0000_000C, 2);

    // Backpressure: result held, a competing request waits for the handshake
    bus.resp_ready = 1'b0;
    do_req(2'b00, 32'h0000_000F, 5'd4, lat, busy_all);
    chk("bp_lat", 32'(lat), 32'd3);
    held = bus.resp_val;
    chk("bp_val", held, 32'h0000_00F0);
    bus.req_op    = SHOP_SRL;
    bus.req_val   = 32'h0000_0100;
    bus.req_sham  = 5'd8;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_val", bus.resp_val, 32'h0000_00F0);
      chk("bp_hold_rdy", {30'd0, bus.req_ready, bus.resp_valid}, 32'b01);
      tick();
    end
    bus.resp_ready = 1'b1;
    chk("bp_hs_rdy", 32'(bus.req_ready), 32'd0);
    tick();
    chk("bp_after_hs", {30'd0, bus.busy, bus.req_ready}, 32'b01);
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    wait_resp(lat, busy_all);
    $display("txn op=1 val=00000100 sham=8 -> resp_val=%h lat=%0d", bus.resp_val, lat);
    chk("bp_next_lat", 32'(lat), 32'd4);
    chk("bp_next_val", bus.resp_val, 32'h0000_0001);
    tick();

    // Flush mid-shift with a concurrent request
    bus.req_op    = SHOP_SRL;
    bus.req_val   = 32'hF000_0000;
    bus.req_sham  = 5'd20;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_sham  = 5'd1;
    chk("fl_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("fl_quiet", {30'd0, bus.busy, bus.resp_valid}, 32'b00);
      tick();
    end
    $display("txn flush abort observed idle");
    run_case("fl_next", 2'b11, 32'hF000_0000, 5'd4, 32'hFF00_0000, 3);

    // Async reset in the middle of a long shift
    bus.req_op    = SHOP_SLL;
    bus.req_val   = 32'h0000_0001;
    bus.req_sham  = 5'd30;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("rs_busy_pre", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async", {29'd0, bus.busy, bus.resp_valid, bus.req_ready}, 32'b001);
    #1 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      chk("rs_quiet", {29'd0, bus.busy, bus.resp_valid, bus.req_ready}, 32'b001);
      tick();
    end
    $display("txn reset abort observed idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
